tag_ram_ctrl: RTL

- Controller for one single-port, synchronous-read tag RAM way in the cache tag path.
- Shares the RAM between two requesters:
  - a lookup requester, which reads an entry and compares tags;
  - an update requester, which fills or invalidates an entry.
- Clears every entry after reset, then serves requests at one per cycle.
- Drives the RAM's addr/din/we pins and consumes its dout.

---
 rtl/tag_ram_pkg.sv | 17 +
 rtl/tag_arb_rr.sv | 38 +++
 rtl/tag_ram_ctrl.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/tag_ram_pkg.sv
// Shared types and constants for the tag RAM controller.
// FSM states, arbiter grant codes and the valid-bit position helper.
package tag_ram_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [1:0] GNT_LK = 2'b01;
  localparam logic [1:0] GNT_UP = 2'b10;

  function automatic int valid_pos(input int dwidth);
    return dwidth - 1;
  endfunction

endpackage

// File: rtl/tag_arb_rr.sv
// Two-requester round-robin arbiter: req[0] = lookup, req[1] = update.
// The last-grant pointer only moves when both requesters compete.
module tag_arb_rr
  import tag_ram_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic last_up_q;
  logic last_up_d;

  always_comb begin
    gnt       = 2'b00;
    last_up_d = last_up_q;
    if (en) begin
      unique case (req)
        2'b11: begin
          gnt       = last_up_q ? GNT_LK : GNT_UP;
          last_up_d = ~last_up_q;
        end
        2'b01:   gnt = GNT_LK;
        2'b10:   gnt = GNT_UP;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Starts as "update" so the first conflict favours lookup.
  always_ff @(posedge clock) begin
    if (reset) last_up_q <= 1'b1;
    else       last_up_q <= last_up_d;
  end

endmodule

// File: rtl/tag_ram_ctrl.sv
// Tag RAM way controller: clear-on-reset, lookup/update sharing one port.
// Optional hit/miss counters when TAG_RAM_CTRL_STATS_EN is defined.
module tag_ram_ctrl
  import tag_ram_pkg::*;
#(
  parameter int AWIDTH = 3,
  parameter int DWIDTH = 14
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              lk_valid,
  output logic              lk_ready,
  input  logic [AWIDTH-1:0] lk_index,
  input  logic [DWIDTH-2:0] lk_tag,
  output logic              rsp_valid,
  output logic              rsp_hit,
  output logic [AWIDTH-1:0] rsp_index,
  input  logic              up_valid,
  output logic              up_ready,
  input  logic [AWIDTH-1:0] up_index,
  input  logic [DWIDTH-2:0] up_tag,
  input  logic              up_inval,
  output logic              init_busy,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_din,
  output logic              ram_we,
  input  logic [DWIDTH-1:0] ram_dout
`ifdef TAG_RAM_CTRL_STATS_EN
  ,
  output logic [15:0]       hit_count,
  output logic [15:0]       miss_count
`endif
);

  localparam int TWIDTH = DWIDTH - 1;
  localparam int VB     = valid_pos(DWIDTH);

  state_e state_q, state_d;
  logic [AWIDTH-1:0] cnt_q, cnt_d;
  logic [AWIDTH-1:0] addr_q;
  logic [1:0]        gnt;
  logic              run_en;

  logic              s1_v_q;
  logic [TWIDTH-1:0] s1_tag_q;
  logic [AWIDTH-1:0] s1_idx_q;
  logic              rsp_v_q, rsp_hit_q;
  logic [AWIDTH-1:0] rsp_idx_q;
  logic              hit_d;

  assign run_en = (state_q == ST_RUN) & ~reset;

  tag_arb_rr u_arb (
    .clock (clock),
    .reset (reset),
    .en    (run_en),
    .req   ({up_valid, lk_valid}),
    .gnt   (gnt)
  );

  assign lk_ready  = gnt[0];
  assign up_ready  = gnt[1];
  assign init_busy = (state_q == ST_INIT);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ram_addr = addr_q;
    ram_din  = '0;
    ram_we   = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        ram_we   = ~reset;
        ram_addr = cnt_q;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == {AWIDTH{1'b1}}) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (gnt == GNT_UP) begin
          ram_we   = 1'b1;
          ram_addr = up_index;
          ram_din  = {~up_inval, up_tag};
        end else if (gnt == GNT_LK) begin
          ram_addr = lk_index;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= ram_addr;
    end
  end

  // ram_dout is valid the cycle after the grant that latched the address.
  assign hit_d = ram_dout[VB] & (ram_dout[TWIDTH-1:0] == s1_tag_q);

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_v_q    <= 1'b0;
      s1_tag_q  <= '0;
      s1_idx_q  <= '0;
      rsp_v_q   <= 1'b0;
      rsp_hit_q <= 1'b0;
      rsp_idx_q <= '0;
    end else begin
      s1_v_q  <= lk_ready;
      rsp_v_q <= s1_v_q;
      if (lk_ready) begin
        s1_tag_q <= lk_tag;
        s1_idx_q <= lk_index;
      end
      if (s1_v_q) begin
        rsp_hit_q <= hit_d;
        rsp_idx_q <= s1_idx_q;
      end
    end
  end

  assign rsp_valid = rsp_v_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_idx_q;

`ifdef TAG_RAM_CTRL_STATS_EN
  logic [15:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (rsp_v_q) begin
      if (rsp_hit_q && hit_cnt_q != 16'hFFFF)
        hit_cnt_q <= hit_cnt_q + 16'd1;
      else if (!rsp_hit_q && miss_cnt_q != 16'hFFFF)
        miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`endif

endmodule
